// File: rtl/axil_stream_regbank_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axil_stream_regbank_if : AXI4-Lite register port (AW/W/B/AR/R channels)
// Rev 1.0
// ---------------------------------------------------------------------------
interface axil_stream_regbank_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface
`default_nettype wire

// File: rtl/axil_stream_regbank.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axil_stream_regbank : AXI4-Lite slave bridging register accesses to
//                       N_WR write streams and N_RD read streams.
// Rev 1.0
// ---------------------------------------------------------------------------
module axil_stream_regbank #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int N_WR    = 8,
  parameter int N_RD    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     aresetn,
  axil_stream_regbank_if.slave     s,
  output logic [N_WR*DATA_W-1:0]   wr_tdata,
  output logic [N_WR-1:0]          wr_tvalid,
  input  logic [N_WR-1:0]          wr_tready,
  input  logic [N_RD*DATA_W-1:0]   rd_tdata,
  input  logic [N_RD-1:0]          rd_tvalid,
  output logic [N_RD-1:0]          rd_tready
);
  localparam int IDX_W  = ADDR_W - 2;
  localparam int STRB_W = DATA_W / 8;
  localparam int WCH_W  = (N_WR > 1) ? $clog2(N_WR) : 1;
  localparam int RCH_W  = (N_RD > 1) ? $clog2(N_RD) : 1;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0]       RESP_OKAY   = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [IDX_W-1:0] N_WR_IDX    = IDX_W'(N_WR);
  localparam logic [IDX_W-1:0] N_RD_IDX    = IDX_W'(N_RD);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {W_IDLE, W_ADDR, W_DATA, W_PUSH, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_PULL, R_RESP} rstate_t;

  wstate_t             w_state, w_state_nx;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [WCH_W-1:0]    wch_q;
  logic [CNT_W-1:0]    w_cnt;
  logic [1:0]          bresp_q;
  logic [DATA_W-1:0]   shadow [N_WR];

  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic [IDX_W-1:0]    w_idx, w_idx_m1;
  logic [WCH_W-1:0]    w_ch;
  logic                w_mapped, w_aw_hs, w_w_hs, w_timeout;
  logic                w_complete, w_commit, w_resp_ld;
  logic [1:0]          w_resp_val;

  // Address/data come from the bus unless that half was captured earlier.
  assign w_addr    = (w_state == W_ADDR) ? awaddr_q : s.awaddr;
  assign w_data    = (w_state == W_DATA) ? wdata_q  : s.wdata;
  assign w_strb    = (w_state == W_DATA) ? wstrb_q  : s.wstrb;
  assign w_idx     = w_addr[ADDR_W-1:2];
  assign w_idx_m1  = w_idx - IDX_W'(1);
  assign w_ch      = w_idx_m1[WCH_W-1:0];
  assign w_mapped  = (w_idx != '0) && (w_idx <= N_WR_IDX);
  assign s.awready = (w_state == W_IDLE) || (w_state == W_DATA);
  assign s.wready  = (w_state == W_IDLE) || (w_state == W_ADDR);
  assign w_aw_hs   = s.awvalid && s.awready;
  assign w_w_hs    = s.wvalid && s.wready;
  assign w_timeout = (TIMEOUT != 0) && (w_cnt == CNT_LAST);
  assign s.bvalid  = (w_state == W_RESP);
  assign s.bresp   = bresp_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = w_state;
    w_complete = 1'b0;
    w_commit   = 1'b0;
    w_resp_ld  = 1'b0;
    w_resp_val = RESP_OKAY;
    case (w_state)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_complete = 1'b1;
        else if (w_aw_hs)      w_state_nx = W_ADDR;
        else if (w_w_hs)       w_state_nx = W_DATA;
      end
      W_ADDR: if (w_w_hs)  w_complete = 1'b1;
      W_DATA: if (w_aw_hs) w_complete = 1'b1;
      W_PUSH: begin
        if (wr_tready[wch_q]) begin
          w_state_nx = W_RESP;
          w_resp_ld  = 1'b1;
        end else if (w_timeout) begin
          w_state_nx = W_RESP;
          w_resp_ld  = 1'b1;
          w_resp_val = RESP_SLVERR;
        end
      end
      W_RESP:  if (s.bready) w_state_nx = W_IDLE;
      default: w_state_nx = W_IDLE;
    endcase
    if (w_complete) begin
      if (w_mapped) begin
        w_state_nx = W_PUSH;
        w_commit   = 1'b1;
      end else begin
        w_state_nx = W_RESP;
        w_resp_ld  = 1'b1;
        w_resp_val = RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wch_q    <= '0;
      w_cnt    <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (w_aw_hs)  awaddr_q <= s.awaddr;
      if (w_w_hs) begin
        wdata_q <= s.wdata;
        wstrb_q <= s.wstrb;
      end
      if (w_commit) wch_q <= w_ch;
      if (w_state != W_PUSH)  w_cnt <= '0;
      else if (w_cnt != '1)   w_cnt <= w_cnt + CNT_W'(1);
      if (w_resp_ld) bresp_q <= w_resp_val;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < N_WR; i++) shadow[i] <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < N_WR; i++)
        if (w_ch == WCH_W'(i))
          for (int b = 0; b < STRB_W; b++)
            if (w_strb[b]) shadow[i][8*b +: 8] <= w_data[8*b +: 8];
    end
  end

  generate
    for (genvar i = 0; i < N_WR; i++) begin : g_wr
      assign wr_tdata[i*DATA_W +: DATA_W] = shadow[i];
      assign wr_tvalid[i] = (w_state == W_PUSH) && (wch_q == WCH_W'(i));
    end
  endgenerate

  rstate_t             r_state, r_state_nx;
  logic [RCH_W-1:0]    rch_q;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          rresp_q;
  logic [DATA_W-1:0]   rd_words [N_RD];
  logic [DATA_W-1:0]   r_status, r_ld_data;
  logic [IDX_W-1:0]    r_idx, r_idx_m1;
  logic                r_mapped, r_timeout, r_ld;
  logic [1:0]          r_ld_resp;

  assign r_idx     = s.araddr[ADDR_W-1:2];
  assign r_idx_m1  = r_idx - IDX_W'(1);
  assign r_mapped  = (r_idx != '0) && (r_idx <= N_RD_IDX);
  assign r_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);
  assign s.arready = (r_state == R_IDLE);
  assign s.rvalid  = (r_state == R_RESP);
  assign s.rdata   = rdata_q;
  assign s.rresp   = rresp_q;

  generate
    for (genvar i = 0; i < N_RD; i++) begin : g_rd
      assign rd_words[i]  = rd_tdata[i*DATA_W +: DATA_W];
      assign rd_tready[i] = (r_state == R_PULL) && (rch_q == RCH_W'(i)) && rd_tvalid[i];
    end
  endgenerate

  always_comb begin
    r_status = '0;
    r_status[N_WR-1:0]     = wr_tready;
    r_status[N_WR +: N_RD] = rd_tvalid;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx = r_state;
    r_ld       = 1'b0;
    r_ld_data  = '0;
    r_ld_resp  = RESP_OKAY;
    case (r_state)
      R_IDLE: begin
        if (s.arvalid) begin
          if (r_idx == '0) begin
            r_state_nx = R_RESP;
            r_ld       = 1'b1;
            r_ld_data  = r_status;
          end else if (!r_mapped) begin
            r_state_nx = R_RESP;
            r_ld       = 1'b1;
            r_ld_resp  = RESP_SLVERR;
          end else begin
            r_state_nx = R_PULL;
          end
        end
      end
      R_PULL: begin
        if (rd_tvalid[rch_q]) begin
          r_state_nx = R_RESP;
          r_ld       = 1'b1;
          r_ld_data  = rd_words[rch_q];
        end else if (r_timeout) begin
          r_state_nx = R_RESP;
          r_ld       = 1'b1;
          r_ld_resp  = RESP_SLVERR;
        end
      end
      R_RESP:  if (s.rready) r_state_nx = R_IDLE;
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rch_q   <= '0;
      r_cnt   <= '0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (s.arvalid && s.arready) rch_q <= r_idx_m1[RCH_W-1:0];
      if (r_state != R_PULL)  r_cnt <= '0;
      else if (r_cnt != '1)   r_cnt <= r_cnt + CNT_W'(1);
      if (r_ld) begin
        rdata_q <= r_ld_data;
        rresp_q <= r_ld_resp;
      end
    end
  end

  // Byte-offset bits and high channel-index bits carry no information here.
  logic unused_bits;
  assign unused_bits = ^{w_addr[1:0], s.araddr[1:0], w_idx_m1, r_idx_m1};
endmodule
`default_nettype wire

// File: tb/tb_axil_stream_regbank.sv
`default_nettype none
`timescale 1ns/1ps
// Self-checking bench for axil_stream_regbank: directed cases followed by
// randomized register traffic checked against a simple array model.
module tb_axil_stream_regbank;
  localparam int ADDR_W = 8, DATA_W = 32, N_WR = 8, N_RD = 8, TIMEOUT = 16;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  axil_stream_regbank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  logic [N_WR*DATA_W-1:0] wr_tdata;
  logic [N_WR-1:0]        wr_tvalid, wr_tready;
  logic [N_RD*DATA_W-1:0] rd_tdata;
  logic [N_RD-1:0]        rd_tvalid, rd_tready;

  axil_stream_regbank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_WR(N_WR),
                        .N_RD(N_RD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .aresetn(aresetn), .s(bus.slave),
    .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
    .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready));

  int vectors = 0, miscompares = 0, pops = 0;
  logic [DATA_W-1:0] shadow_m [N_WR];

  always @(posedge clk) pops <= pops + $countones(rd_tready & rd_tvalid);

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_WR*DATA_W-1:0] model_flat();
    logic [N_WR*DATA_W-1:0] v;
    for (int i = 0; i < N_WR; i++) v[i*DATA_W +: DATA_W] = shadow_m[i];
    return v;
  endfunction

  // Reference write rule: mapped index 1..N_WR merges enabled bytes, else SLVERR.
  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] d,
                                             input logic [3:0] strb);
    int idx = int'(addr[7:2]);
    if (idx < 1 || idx > N_WR) return SLVERR;
    for (int b = 0; b < 4; b++)
      if (strb[b]) shadow_m[idx-1][8*b +: 8] = d[8*b +: 8];
    return OKAY;
  endfunction

  task automatic do_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] strb,
                          input int lead, output logic [1:0] resp, output int tvc, output int lat);
    int n, guard;
    bit af, wf;
    @(negedge clk);
    bus.wdata = d; bus.wstrb = strb; bus.wvalid = 1'b1;
    bus.awaddr = addr; bus.awvalid = (lead == 0);
    n = 0; tvc = 0;
    while ((bus.awvalid || bus.wvalid || n < lead) && n < 64) begin
      af = bus.awvalid && bus.awready;
      wf = bus.wvalid && bus.wready;
      @(negedge clk);
      n++;
      if (af) bus.awvalid = 1'b0;
      if (wf) bus.wvalid = 1'b0;
      if (n == lead) bus.awvalid = 1'b1;
    end
    bus.bready = 1'b1;
    guard = 0;
    while (!bus.bvalid && guard < 64) begin
      if (wr_tvalid != '0) tvc++;
      @(negedge clk);
      guard++;
    end
    lat = n - lead + guard;
    chk("bvalid_seen", bus.bvalid, 1'b1);
    resp = bus.bresp;
    @(negedge clk);
    bus.bready = 1'b0;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr, input int delay, input logic [31:0] pdata,
                         input int rwait, output logic [31:0] d, output logic [1:0] resp);
    int idx, guard;
    logic [31:0] held;
    idx = int'(addr[7:2]);
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    guard = 0;
    while (!bus.arready && guard < 64) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus.arvalid = 1'b0;
    if (idx >= 1 && idx <= N_RD && delay >= 0) begin
      repeat (delay) @(negedge clk);
      rd_tdata[(idx-1)*DATA_W +: DATA_W] = pdata;
      rd_tvalid[idx-1] = 1'b1;
      @(negedge clk);
      rd_tvalid[idx-1] = 1'b0;
    end
    guard = 0;
    while (!bus.rvalid && guard < 64) begin @(negedge clk); guard++; end
    chk("rvalid_seen", bus.rvalid, 1'b1);
    held = bus.rdata;
    for (int k = 0; k < rwait; k++) begin
      @(negedge clk);
      chk("rdata_hold", {bus.rvalid, bus.rdata}, {1'b1, held});
    end
    bus.rready = 1'b1;
    d = bus.rdata; resp = bus.rresp;
    @(negedge clk);
    bus.rready = 1'b0;
    chk("rvalid_drop", bus.rvalid, 1'b0);
  endtask

  initial begin
    logic [1:0] resp, eresp;
    logic [31:0] rd, d, pd;
    logic [7:0] a;
    logic [3:0] strb;
    int tvc, lat, p0, idx, lead;

    bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 0;
    bus.bready = 0; bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
    wr_tready = '0; rd_tdata = '0; rd_tvalid = '0;
    for (int i = 0; i < N_WR; i++) shadow_m[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    chk("rst_valid", {bus.bvalid, bus.rvalid}, 2'b00);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_resp", {bus.bresp, bus.rresp}, 4'h0);
    chk("rst_stream", {wr_tvalid, rd_tready}, 16'h0);
    chk("rst_shadow", wr_tdata, '0);
    aresetn = 1'b1;

    // AW+W together, index 2
    wr_tready = '1;
    do_write(8'h08, 32'hA5A5_0001, 4'hF, 0, resp, tvc, lat);
    eresp = model_write(8'h08, 32'hA5A5_0001, 4'hF);
    chk("wr1_resp", resp, eresp);
    chk("wr1_tvalid_cycles", tvc, 1);
    chk("wr1_latency", lat, 2);
    chk("wr1_tdata1", wr_tdata[DATA_W +: DATA_W], 32'hA5A5_0001);

    // W leads AW by 3 cycles, single byte strobe
    do_write(8'h08, 32'h0000_00FF, 4'b0001, 3, resp, tvc, lat);
    eresp = model_write(8'h08, 32'h0000_00FF, 4'b0001);
    chk("wr2_resp", resp, OKAY);
    chk("wr2_tdata1", wr_tdata[DATA_W +: DATA_W], 32'hA5A5_00FF);
    chk("wr2_all", wr_tdata, model_flat());

    // Write stream stalls: timeout after TIMEOUT cycles of tvalid
    wr_tready = '0;
    do_write(8'h0C, 32'hDEAD_BEEF, 4'hF, 0, resp, tvc, lat);
    eresp = model_write(8'h0C, 32'hDEAD_BEEF, 4'hF);
    chk("wto_tvalid_cycles", tvc, TIMEOUT);
    chk("wto_resp", resp, SLVERR);
    chk("wto_tvalid_low", wr_tvalid, 8'h00);
    wr_tready = '1;

    // Read index 3, producer late by 5 cycles, rready held off 4 cycles
    p0 = pops;
    do_read(8'h0C, 5, 32'h0000_1234, 4, rd, resp);
    chk("rd3_data", rd, 32'h0000_1234);
    chk("rd3_resp", resp, OKAY);
    chk("rd3_pops", pops - p0, 1);

    // Status register
    rd_tvalid = 8'h05; wr_tready = 8'h81;
    p0 = pops;
    do_read(8'h00, -1, 32'h0, 0, rd, resp);
    chk("stat_data", rd, 32'h0000_0581);
    chk("stat_resp", resp, OKAY);
    chk("stat_pops", pops - p0, 0);
    rd_tvalid = '0; wr_tready = '1;

    // Unmapped accesses and read timeout
    do_write(8'h00, 32'h1111_2222, 4'hF, 0, resp, tvc, lat);
    chk("wr0_resp", resp, SLVERR);
    chk("wr0_tvalid_cycles", tvc, 0);
    chk("wr0_unchanged", wr_tdata, model_flat());
    do_read(8'((N_RD + 1) << 2), 0, 32'hFFFF_FFFF, 0, rd, resp);
    chk("rd9_resp", resp, SLVERR);
    chk("rd9_data", rd, 32'h0);
    p0 = pops;
    do_read(8'h10, -1, 32'h0, 0, rd, resp);
    chk("rto_resp", resp, SLVERR);
    chk("rto_data", rd, 32'h0);
    chk("rto_pops", pops - p0, 0);

    // Asynchronous reset while a push is pending
    wr_tready = '0;
    @(negedge clk);
    bus.awaddr = 8'h08; bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    chk("arst_push_active", wr_tvalid, 8'h02);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_tvalid", wr_tvalid, 8'h00);
    chk("arst_bvalid", bus.bvalid, 1'b0);
    chk("arst_ready", {bus.awready, bus.wready, bus.arready}, 3'b111);
    chk("arst_shadow", wr_tdata, '0);
    for (int i = 0; i < N_WR; i++) shadow_m[i] = '0;
    @(negedge clk);
    aresetn = 1'b1;
    wr_tready = '1;
    do_write(8'h08, 32'h0BAD_F00D, 4'hF, 0, resp, tvc, lat);
    eresp = model_write(8'h08, 32'h0BAD_F00D, 4'hF);
    chk("post_rst_resp", resp, OKAY);
    chk("post_rst_tdata", wr_tdata, model_flat());

    // Randomized traffic
    for (int k = 0; k < 24; k++) begin
      idx  = $urandom_range(0, N_WR + 1);
      a    = 8'(idx << 2);
      d    = $urandom;
      strb = 4'($urandom_range(0, 15));
      lead = $urandom_range(0, 2);
      do_write(a, d, strb, lead, resp, tvc, lat);
      eresp = model_write(a, d, strb);
      chk("rnd_wr_resp", resp, eresp);
      chk("rnd_wr_tvalid_cycles", tvc, (eresp == OKAY) ? 1 : 0);
      chk("rnd_wr_tdata", wr_tdata, model_flat());

      idx = $urandom_range(0, N_RD + 1);
      a   = 8'(idx << 2);
      pd  = $urandom;
      p0  = pops;
      if (idx == 0) wr_tready = 8'($urandom);
      do_read(a, $urandom_range(0, 6), pd, $urandom_range(0, 2), rd, resp);
      if (idx == 0) begin
        chk("rnd_stat", {resp, rd}, {OKAY, 16'h0, rd_tvalid, wr_tready});
        wr_tready = '1;
      end else if (idx <= N_RD) begin
        chk("rnd_rd", {resp, rd}, {OKAY, pd});
      end else begin
        chk("rnd_rd_unmapped", {resp, rd}, {SLVERR, 32'h0});
      end
      chk("rnd_rd_pops", pops - p0, (idx >= 1 && idx <= N_RD) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
